// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_cmd_pkg : state encoding and ASCII constants for uart_cmd_decoder   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_EOL   = 3'd3,
    S_FLUSH = 3'd4,
    S_REQ   = 3'd5
  } state_t;

  localparam logic [7:0] c_CHR_CR   = 8'h0D;
  localparam logic [7:0] c_CHR_LF   = 8'h0A;
  localparam logic [7:0] c_CHR_SP   = 8'h20;
  localparam logic [7:0] c_CHR_W_UP = 8'h57;
  localparam logic [7:0] c_CHR_W_LO = 8'h77;
  localparam logic [7:0] c_CHR_R_UP = 8'h52;
  localparam logic [7:0] c_CHR_R_LO = 8'h72;
  localparam logic [7:0] c_CHR_K    = 8'h4B;
  localparam logic [7:0] c_CHR_QM   = 8'h3F;
  localparam logic [7:0] c_CHR_T    = 8'h54;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_cmd_decoder_if : RX byte stream, card_driver requests, status out   |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
interface uart_cmd_decoder_if;
  logic        RX_STB;
  logic [7:0]  RX_DAT;
  logic        WR_STB;
  logic [31:0] WR_ADDR;
  logic [31:0] WR_LENGTH;
  logic        WR_ACK;
  logic        RD_STB;
  logic [31:0] RD_ADDR;
  logic [31:0] RD_LENGTH;
  logic        RD_ACK;
  logic        ST_STB;
  logic [7:0]  ST_DAT;
  logic        ST_BUSY;

  modport master (
    input  RX_STB, RX_DAT, WR_ACK, RD_ACK, ST_BUSY,
    output WR_STB, WR_ADDR, WR_LENGTH, RD_STB, RD_ADDR, RD_LENGTH, ST_STB, ST_DAT
  );

  modport slave (
    output RX_STB, RX_DAT, WR_ACK, RD_ACK, ST_BUSY,
    input  WR_STB, WR_ADDR, WR_LENGTH, RD_STB, RD_ADDR, RD_LENGTH, ST_STB, ST_DAT
  );
endinterface
`default_nettype wire

// File: rtl/hex_nibble_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_nibble_decode : ASCII hex character to {valid, nibble}               |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module hex_nibble_decode (
  input  logic [7:0] i_char,
  output logic       o_valid,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_valid  = 1'b0;
    o_nibble = 4'd0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      o_valid  = 1'b1;
      o_nibble = i_char[3:0];
    end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                 (i_char >= 8'h61 && i_char <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 yields 10
      o_valid  = 1'b1;
      o_nibble = i_char[3:0] + 4'd9;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_cmd_decoder : parses "Caaaaaaaallllllll\r" frames into card_driver  |
// |                    read/write requests and returns a status character    |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module uart_cmd_decoder #(
  parameter int CLK_MHZ    = 50,
  parameter int TIMEOUT_US = 1000,
  parameter int TO_W       = 17
) (
  input  logic                CLOCK50,
  input  logic                RESET,
  uart_cmd_decoder_if.master  bus
);
  import uart_cmd_pkg::*;

  localparam logic [TO_W-1:0] c_TO_TERM = TO_W'(CLK_MHZ * TIMEOUT_US - 1);

  state_t          r_state, w_state_nx;
  logic            r_is_wr, w_is_wr_nx;
  logic [31:0]     r_addr, w_addr_nx;
  logic [31:0]     r_len, w_len_nx;
  logic [2:0]      r_cnt, w_cnt_nx;
  logic [TO_W-1:0] r_to, w_to_nx;
  logic            r_pend, w_pend_nx;
  logic [7:0]      r_pend_dat, w_pend_dat_nx;

  logic            w_hex_vld;
  logic [3:0]      w_hex_nib;
  logic            w_rx;
  logic            w_is_cmd;
  logic            w_is_ws;
  logic            w_ack;
  logic            w_req;
  logic            w_to_active;

  hex_nibble_decode u_hex (
    .i_char   (bus.RX_DAT),
    .o_valid  (w_hex_vld),
    .o_nibble (w_hex_nib)
  );

  // A pending status byte blocks the next frame from starting
  assign w_rx     = bus.RX_STB && !r_pend;
  assign w_is_cmd = (bus.RX_DAT == c_CHR_W_UP) || (bus.RX_DAT == c_CHR_W_LO) ||
                    (bus.RX_DAT == c_CHR_R_UP) || (bus.RX_DAT == c_CHR_R_LO);
  assign w_is_ws  = (bus.RX_DAT == c_CHR_CR) || (bus.RX_DAT == c_CHR_LF) ||
                    (bus.RX_DAT == c_CHR_SP);
  assign w_ack    = r_is_wr ? bus.WR_ACK : bus.RD_ACK;
  assign w_req    = (r_state == S_REQ);
  assign w_to_active = (r_state == S_ADDR) || (r_state == S_LEN) ||
                       (r_state == S_EOL)  || (r_state == S_FLUSH);

  always_ff @(posedge CLOCK50 or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_to       <= '0;
      r_pend     <= 1'b0;
      r_pend_dat <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_is_wr    <= w_is_wr_nx;
      r_addr     <= w_addr_nx;
      r_len      <= w_len_nx;
      r_cnt      <= w_cnt_nx;
      r_to       <= w_to_nx;
      r_pend     <= w_pend_nx;
      r_pend_dat <= w_pend_dat_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_is_wr_nx    = r_is_wr;
    w_addr_nx     = r_addr;
    w_len_nx      = r_len;
    w_cnt_nx      = r_cnt;
    w_to_nx       = '0;
    w_pend_nx     = r_pend && bus.ST_BUSY;
    w_pend_dat_nx = r_pend_dat;

    unique case (r_state)
      S_IDLE: begin
        if (w_rx) begin
          if (w_is_cmd) begin
            w_is_wr_nx = (bus.RX_DAT == c_CHR_W_UP) || (bus.RX_DAT == c_CHR_W_LO);
            w_addr_nx  = '0;
            w_cnt_nx   = '0;
            w_state_nx = S_ADDR;
          end else if (!w_is_ws) begin
            w_state_nx = S_FLUSH;
          end
        end
      end
      S_ADDR, S_LEN: begin
        if (w_rx) begin
          if (!w_hex_vld) begin
            w_state_nx = S_FLUSH;
          end else begin
            w_cnt_nx = r_cnt + 3'd1;
            if (r_state == S_ADDR) w_addr_nx = {r_addr[27:0], w_hex_nib};
            else                   w_len_nx  = {r_len[27:0], w_hex_nib};
            if (r_cnt == 3'd7) begin
              w_cnt_nx   = '0;
              w_state_nx = (r_state == S_ADDR) ? S_LEN : S_EOL;
              if (r_state == S_ADDR) w_len_nx = '0;
            end
          end
        end
      end
      S_EOL: begin
        if (w_rx) begin
          if (bus.RX_DAT != c_CHR_CR) begin
            w_state_nx = S_FLUSH;
          end else if (r_len != 32'd0) begin
            w_state_nx = S_REQ;
          end else begin
            w_pend_nx     = 1'b1;
            w_pend_dat_nx = c_CHR_QM;
            w_state_nx    = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (w_rx && bus.RX_DAT == c_CHR_CR) begin
          w_pend_nx     = 1'b1;
          w_pend_dat_nx = c_CHR_QM;
          w_state_nx    = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_ack) begin
          w_pend_nx     = 1'b1;
          w_pend_dat_nx = c_CHR_K;
          w_state_nx    = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // A byte arriving on the terminal count keeps the frame alive
    if (w_to_active && !bus.RX_STB) begin
      if (r_to == c_TO_TERM) begin
        w_pend_nx     = 1'b1;
        w_pend_dat_nx = c_CHR_T;
        w_state_nx    = S_IDLE;
      end else begin
        w_to_nx = r_to + TO_W'(1);
      end
    end
  end

  assign bus.WR_STB    = w_req && r_is_wr;
  assign bus.RD_STB    = w_req && !r_is_wr;
  assign bus.WR_ADDR   = bus.WR_STB ? r_addr : 32'd0;
  assign bus.WR_LENGTH = bus.WR_STB ? r_len  : 32'd0;
  assign bus.RD_ADDR   = bus.RD_STB ? r_addr : 32'd0;
  assign bus.RD_LENGTH = bus.RD_STB ? r_len  : 32'd0;
  assign bus.ST_STB    = r_pend && !bus.ST_BUSY;
  assign bus.ST_DAT    = bus.ST_STB ? r_pend_dat : 8'd0;

endmodule
`default_nettype wire

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Receives ASCII command frames byte-by-byte from the UART RX path (dev_uart_asy RX_STB/RX_DAT).
- Turns each valid frame into a single write-request or read-request handshake towards card_driver (WR_*/RD_* request ports).
- Returns a one-byte status character ('K', '?', 'T') on a status stream that feeds the TX FIFO.
- Sits between the UART receiver and card_driver; replaces the hard-coded burst test sequencer in the tester top.

Parameters:
- CLK_MHZ, 50, clock frequency in MHz; used only for the timeout.
- TIMEOUT_US, 1000, maximum gap between bytes inside a frame before the frame is aborted.
- TO_W, 17, width of the timeout counter; must hold CLK_MHZ*TIMEOUT_US.

Ports:
- CLOCK50  in  1  system clock, all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RX_STB  in  1  one-cycle strobe: RX_DAT valid; always consumed, never back-pressured.
- RX_DAT  in  8  received byte.
- WR_STB  out  1  write request; held until WR_ACK.
- WR_ADDR  out  32  write start address.
- WR_LENGTH  out  32  write length in bytes.
- WR_ACK  in  1  card_driver accepted the write request.
- RD_STB  out  1  read request; held until RD_ACK.
- RD_ADDR  out  32  read start address.
- RD_LENGTH  out  32  read length in bytes.
- RD_ACK  in  1  card_driver accepted the read request.
- ST_STB  out  1  one-cycle status byte strobe.
- ST_DAT  out  8  status byte.
- ST_BUSY  in  1  status sink cannot accept a byte (FIFO AlmostFull).

Behaviour:

Reset:
- All outputs are 0. State is IDLE; digit counter, timeout counter and shift registers are 0.

Frame format:
- cmd, then 8 hex digits of address (MSB first), then 8 hex digits of length (MSB first), then CR (0x0D).
- cmd is 'W'/'w' (write) or 'R'/'r' (read).
- Hex digits are 0-9, A-F, a-f.

States:
- IDLE:
  - cmd byte -> latch the kind, clear the address shift register, digit count = 0, go to ADDR.
  - CR, LF or space -> ignored.
  - Any other byte -> go to FLUSH.
- ADDR:
  - Each hex digit: addr = {addr[27:0], nibble}, count+1.
  - On the 8th digit go to LEN with count = 0.
  - Non-hex byte -> FLUSH.
- LEN:
  - Same shifting into the length register.
  - On the 8th digit go to EOL.
  - Non-hex byte -> FLUSH.
- EOL:
  - CR with length != 0 -> go to REQ.
  - CR with length == 0 -> status '?', go to IDLE.
  - Any other byte -> FLUSH.
- FLUSH:
  - Discard bytes until CR.
  - On CR: status '?', go to IDLE.
- REQ:
  - Drive {WR|RD}_ADDR/LENGTH from the shift registers and assert the matching STB.
  - Hold STB and the address/length stable until the matching ACK is sampled high.
  - The cycle after ACK: STB = 0, status 'K', go to IDLE.
  - The other channel's STB stays 0 throughout.
- Bytes arriving in REQ, or while a status byte is pending, are dropped silently.

Status output:
- The status character is held in a pending register.
- ST_STB = 1 for exactly one cycle, in the first cycle in which pending is set and ST_BUSY = 0.
- Pending clears in that same cycle. At most one status byte is pending at a time.
- A new frame's status overwrites nothing: parsing of the next frame is not accepted in IDLE until pending has cleared (those bytes are dropped).

Timeout:
- In ADDR, LEN, EOL and FLUSH the timeout counter increments every cycle without RX_STB and resets on RX_STB.
- When it reaches CLK_MHZ*TIMEOUT_US-1: status 'T', go to IDLE.
- The counter is held at 0 in IDLE and REQ.
- REQ has no timeout.

Simultaneous events:
- RX_STB in the same cycle as the timeout terminal count: the byte wins and the counter resets.
- ACK arriving in the first REQ cycle is legal: 1-cycle STB.

Latency:
- CR byte at cycle n -> STB = 1 at cycle n+1.
- ACK at cycle m -> STB = 0 and ST_STB = 1 at cycle m+1, provided ST_BUSY = 0.

Reset mid-operation:
- Any request is dropped immediately (STB goes to 0 asynchronously).
- Partial frames are lost.

Decomposition:
- Package uart_cmd_pkg:
  - State encoding: IDLE, ADDR, LEN, EOL, FLUSH, REQ.
  - Character constants: CR, LF, ' ', 'W', 'w', 'R', 'r', 'K', '?', 'T'.
- Sub-module hex_nibble_decode:
  - Combinational; maps an 8-bit ASCII byte to {valid, nibble[3:0]}.
  - Instanced once and shared by ADDR and LEN.

Test Plan:
- "W0000271000002710\r", WR_ACK 3 cycles after WR_STB rises -> WR_ADDR = 0x00002710, WR_LENGTH = 0x2710; WR_STB high for exactly 4 cycles; RD_STB stays 0; one ST_STB with 'K'.
- "r000000ff0000000A\r", RD_ACK tied high -> RD_ADDR = 0xFF, RD_LENGTH = 10; RD_STB high 1 cycle; status 'K'.
- "W00G0..." then "\r" -> no WR_STB; one status '?' on CR. Repeat with length 00000000 -> '?', no request.
- Send "W0000" then stop for 50000 cycles (CLK_MHZ 50, TIMEOUT_US 1000) -> status 'T' at gap cycle 49999; a following valid frame is accepted normally.
- ST_BUSY held 1 during the 'K' status for 20 cycles -> ST_STB asserts in the cycle ST_BUSY drops, exactly once; RX bytes sent during that window are dropped, and no request results.
- RESET pulsed while WR_STB is waiting for ACK -> WR_STB, ADDR and LENGTH are 0 immediately; no status byte; the next frame works.
